// File: rtl/ternary_neuron_acc.sv
// ternary_neuron_acc: accumulates signed (pos - neg) popcount differences over
// one or more 27-input chunks, then thresholds the sum into a ternary
// activation {+1, 0, -1} presented on a valid/ready output.
// Optional build macro TNEURON_ACC_SAT_EN: saturate the running sum at ACC_W
// instead of wrapping two's complement.
module ternary_neuron_acc #(
  parameter int ACC_W      = 10,
  parameter int MAX_CHUNKS = 16,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_pos,
  input  logic [4:0]              in_neg,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_trunc
);

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        chunk_cnt;
  logic signed [5:0]       diff6;
  logic signed [ACC_W-1:0] diff;
  logic signed [ACC_W-1:0] nsum;
  logic                    accept;
  logic                    final_beat;

`ifdef TNEURON_ACC_SAT_EN
  // Clamp a one-bit-wider sum into the ACC_W signed range.
  function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    if (s[ACC_W] != s[ACC_W-1]) begin
      r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r = s[ACC_W-1:0];
    end
    return r;
  endfunction
`endif

  assign accept     = in_valid & in_ready;
  assign final_beat = in_last | (chunk_cnt == CNT_W'(MAX_CHUNKS - 1));

  // Per-chunk difference and the candidate running sum.
  always_comb begin
    diff6 = $signed({1'b0, in_pos}) - $signed({1'b0, in_neg});
    diff  = {{(ACC_W-6){diff6[5]}}, diff6};
`ifdef TNEURON_ACC_SAT_EN
    nsum  = sat_sum({acc[ACC_W-1], acc} + {diff[ACC_W-1], diff});
`else
    nsum  = acc + diff;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (accept && final_beat) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Accumulator, chunk counter and result capture on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      chunk_cnt <= '0;
      out_act   <= 2'b00;
      out_sum   <= '0;
      out_trunc <= 1'b0;
    end else if (accept) begin
      if (final_beat) begin
        out_sum   <= nsum;
        out_trunc <= ~in_last;
        if (nsum >= thr_hi)      out_act <= 2'b01;
        else if (nsum <= thr_lo) out_act <= 2'b11;
        else                     out_act <= 2'b00;
        acc       <= '0;
        chunk_cnt <= '0;
      end else begin
        acc       <= nsum;
        chunk_cnt <= chunk_cnt + 1'b1;
      end
    end
  end

endmodule
